// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM between the fetch requester (inst,
// read-only) and the EXE/MEM requester (data, read/write). Data has fixed
// priority. A starvation counter forces a fetch grant once inst has lost
// STARVE_LIMIT consecutive contested cycles. One transaction is issued per
// cycle. Its response (data_ok plus rdata) appears exactly one cycle later.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_req/inst_addr          fetch request in
//   inst_addr_ok/inst_data_ok   fetch accept / read-data-valid out
//   inst_rdata                  fetch read data out
//   data_req/data_wr/data_wstrb/data_addr/data_wdata   data request in
//   data_addr_ok/data_data_ok   data accept / response-valid out
//   data_rdata                  data read data out
//   mem_en/mem_we/mem_addr/mem_wdata   SRAM command out
//   mem_rdata                   SRAM read data in (valid the cycle after mem_en)
//
// Note: addr_ok and the mem_* command lines must be combinational. This is
// required for 1-per-cycle issue. The rdata outputs are a combinational
// pass-through of the SRAM output register.

module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    logic       grant_inst_s;
    logic       grant_data_s;
    logic [3:0] starve_cnt_nxt_s;
    logic       rsp_valid_r;
    logic       rsp_owner_r;    // 1'b0 = inst, 1'b1 = data
    logic [3:0] starve_cnt_r;

    // Grant decision: data first, unless inst has reached the starvation limit.
    // No grant at all while reset is high.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (reset) begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end else begin
            case ({inst_req, data_req})
                2'b10:   grant_inst_s = 1'b1;
                2'b01:   grant_data_s = 1'b1;
                2'b11: begin
                    if (starve_cnt_r == STARVE_LIMIT_C) begin
                        grant_inst_s = 1'b1;
                    end else begin
                        grant_data_s = 1'b1;
                    end
                end
                default: begin
                    grant_inst_s = 1'b0;
                    grant_data_s = 1'b0;
                end
            endcase
        end
    end

    // SRAM command mux: the winner drives address and data. Only a data write drives byte enables.
    always_comb begin
        mem_en    = grant_inst_s | grant_data_s;
        mem_we    = 4'b0000;
        mem_addr  = inst_addr;
        mem_wdata = 32'h0000_0000;
        if (grant_data_s) begin
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            if (data_wr) begin
                mem_we = data_wstrb;
            end else begin
                mem_we = 4'b0000;
            end
        end else begin
            mem_addr  = inst_addr;
            mem_wdata = 32'h0000_0000;
        end
    end

    // Starvation counter next value: count contested losses, saturating.
    // Clear when inst is served or idle.
    always_comb begin
        starve_cnt_nxt_s = 4'd0;
        if (inst_req && !grant_inst_s) begin
            if (starve_cnt_r == STARVE_LIMIT_C) begin
                starve_cnt_nxt_s = starve_cnt_r;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_nxt_s = 4'd0;
        end
    end

    // In-flight response tracking and starvation state. Reset drops any response in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r  <= 1'b0;
            rsp_owner_r  <= 1'b0;
            starve_cnt_r <= 4'd0;
        end else begin
            rsp_valid_r  <= grant_inst_s | grant_data_s;
            rsp_owner_r  <= grant_data_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    assign inst_addr_ok = grant_inst_s;
    assign data_addr_ok = grant_data_s;
    assign inst_data_ok = rsp_valid_r & ~rsp_owner_r;
    assign data_data_ok = rsp_valid_r &  rsp_owner_r;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter. A behavioural
// synchronous SRAM supplies mem_rdata. Inputs change 1 time unit after
// posedge. Outputs are sampled on negedge.

module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Behavioural single-port synchronous SRAM, word-keyed, read-before-write.
    bit [31:0] mem [bit [31:0]];
    bit [31:0] mem_key;
    bit [31:0] mem_word;

    // SRAM model: register the old word and merge write bytes on each enabled cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_key  = mem_addr >> 2;
            mem_word = mem.exists(mem_key) ? mem[mem_key] : 32'h0000_0000;
            mem_rdata <= mem_word;
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_word[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem[mem_key] = mem_word;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Grant pattern under full contention with STARVE_LIMIT=4 (1 = inst wins).
    logic [9:0] pat;

    initial begin
        pat = 10'b10000_10000;  // bit i = grant for cycle i: D,D,D,D,I,D,D,D,D,I
        mem_rdata = 32'h0000_0000;
        mem[32'h0000_0000] = 32'h1000_0000;
        mem[32'h0000_0001] = 32'h1000_0004;
        mem[32'h0000_0002] = 32'h1000_0008;
        mem[32'h0700_0000] = 32'h0280_0c0c;   // 0x1c000000 >> 2
        mem[32'h0000_0040] = 32'h1122_3344;   // 0x100 >> 2

        // Reset held with both requests active (data posing as a full write).
        reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
        data_addr = 32'h0000_0000; data_wdata = 32'hdead_beef;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            check_val("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            check_val("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
            check_val("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
            check_val("rst_data_data_ok", 32'(data_data_ok), 32'd0);
            check_val("rst_mem_en", 32'(mem_en), 32'd0);
            check_val("rst_mem_we", 32'(mem_we), 32'd0);
        end

        // First cycle after reset: data wins against inst.
        next_cycle();
        reset = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        @(negedge clk);
        check_val("post_rst_data_grant", 32'(data_addr_ok), 32'd1);
        check_val("post_rst_inst_grant", 32'(inst_addr_ok), 32'd0);
        check_val("post_rst_mem_en", 32'(mem_en), 32'd1);
        next_cycle();
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        check_val("post_rst_data_ok", 32'(data_data_ok), 32'd1);
        check_val("post_rst_rdata", data_rdata, 32'h1000_0000);
        check_val("post_rst_inst_ok", 32'(inst_data_ok), 32'd0);

        // Single fetch.
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        @(negedge clk);
        check_val("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
        check_val("fetch_mem_addr", mem_addr, 32'h1c00_0000);
        check_val("fetch_mem_we", 32'(mem_we), 32'd0);
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        check_val("fetch_data_ok", 32'(inst_data_ok), 32'd1);
        check_val("fetch_rdata", inst_rdata, 32'h0280_0c0c);
        check_val("fetch_no_data_ok", 32'(data_data_ok), 32'd0);

        // Partial write then read back.
        next_cycle();
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h0000_0100; data_wdata = 32'haabb_ccdd;
        @(negedge clk);
        check_val("wr_addr_ok", 32'(data_addr_ok), 32'd1);
        check_val("wr_mem_we", 32'(mem_we), 32'h3);
        check_val("wr_mem_wdata", mem_wdata, 32'haabb_ccdd);
        next_cycle();
        data_wr = 1'b0; data_wstrb = 4'b0000;
        @(negedge clk);
        check_val("wr_data_ok", 32'(data_data_ok), 32'd1);
        check_val("rd_mem_we", 32'(mem_we), 32'd0);
        check_val("rd_addr_ok", 32'(data_addr_ok), 32'd1);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check_val("rd_data_ok", 32'(data_data_ok), 32'd1);
        check_val("rd_rdata", data_rdata, 32'h1122_ccdd);

        // Full contention: starvation forces inst every fifth cycle.
        next_cycle();
        inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h0000_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val($sformatf("cont_inst_grant_%0d", i), 32'(inst_addr_ok), 32'(pat[i]));
            check_val($sformatf("cont_data_grant_%0d", i), 32'(data_addr_ok), 32'(!pat[i]));
            if (i > 0) begin
                check_val($sformatf("cont_inst_ok_%0d", i), 32'(inst_data_ok), 32'(pat[i-1]));
                check_val($sformatf("cont_data_ok_%0d", i), 32'(data_data_ok), 32'(!pat[i-1]));
            end
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);
        check_val("cont_inst_ok_last", 32'(inst_data_ok), 32'd1);
        check_val("cont_data_ok_last", 32'(data_data_ok), 32'd0);
        check_val("cont_inst_rdata_last", inst_rdata, 32'h0280_0c0c);

        // Back-to-back data reads.
        next_cycle();
        data_req = 1'b1; data_addr = 32'h0000_0000;
        @(negedge clk);
        check_val("b2b_addr_ok_0", 32'(data_addr_ok), 32'd1);
        next_cycle();
        data_addr = 32'h0000_0004;
        @(negedge clk);
        check_val("b2b_addr_ok_1", 32'(data_addr_ok), 32'd1);
        check_val("b2b_data_ok_0", 32'(data_data_ok), 32'd1);
        check_val("b2b_rdata_0", data_rdata, 32'h1000_0000);
        next_cycle();
        data_addr = 32'h0000_0008;
        @(negedge clk);
        check_val("b2b_addr_ok_2", 32'(data_addr_ok), 32'd1);
        check_val("b2b_data_ok_1", 32'(data_data_ok), 32'd1);
        check_val("b2b_rdata_1", data_rdata, 32'h1000_0004);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check_val("b2b_data_ok_2", 32'(data_data_ok), 32'd1);
        check_val("b2b_rdata_2", data_rdata, 32'h1000_0008);
        check_val("b2b_idle_addr_ok", 32'(data_addr_ok), 32'd0);

        // Reset mid-operation: build up starvation, then reset while inst alone requests.
        next_cycle();
        inst_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        reset = 1'b1; data_req = 1'b0;
        @(negedge clk);
        check_val("mid_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check_val("mid_rst_mem_en", 32'(mem_en), 32'd0);
        next_cycle();
        reset = 1'b0; data_req = 1'b1;
        @(negedge clk);
        check_val("mid_rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check_val("mid_rst_data_data_ok", 32'(data_data_ok), 32'd0);
        check_val("mid_rst_starve_cnt", 32'(dut.starve_cnt_r), 32'd0);
        // Starvation restarts from zero: four data grants, then inst.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check_val($sformatf("mid_rst_inst_grant_%0d", i), 32'(inst_addr_ok), 32'(pat[i]));
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
